// File: rtl/elink_rx_deframer_2bit_if.sv
`default_nettype none
// ============================================================================
// Module      : elink_rx_deframer_2bit_if
// Description : Frame output handshake between the e-link deframer and the
//               bus-side emulator.
//                 frame_data  [75:0] recovered payload, MSB first
//                 frame_valid        frame_data holds an unconsumed frame
//                 frame_ready        consumer accepts the frame
//               master = deframer (producer), slave = consumer.
// Revision    : 1.0  initial release
// ============================================================================
interface elink_rx_deframer_2bit_if;
   logic [75:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;

   modport master (output frame_data, output frame_valid, input frame_ready);
   modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface
`default_nettype wire

// File: rtl/elink_rx_deframer_2bit.sv
`default_nettype none
// ============================================================================
// Module      : elink_rx_deframer_2bit
// Description : Recovers 76-bit command frames from a 2-bit e-link stream.
//               Wire format (MSB first): SOP(4 sym) PAYLOAD(38) CHK(4) EOP(4).
//               CHK is the XOR of the 10 bytes of {payload, 4'b0000}.
//               Good frames go out on a valid/ready handshake; bad frames
//               are counted and dropped.
// Ports       : clk, rst          clock, synchronous active-high reset
//               enable            low forces IDLE, partial frame discarded
//               rx_elink2bit[1:0] serial symbol, bit [1] is the earlier bit
//               m_frame           frame_data / frame_valid / frame_ready
//               frame_err         1-cycle pulse on checksum or EOP failure
//               overflow          1-cycle pulse when a good frame is dropped
//               err_cnt[7:0]      saturating bad-frame count
//               frame_cnt[15:0]   wrapping good-frame-loaded count
//               busy              high outside IDLE
// Revision    : 1.0  initial release
// ============================================================================
module elink_rx_deframer_2bit #(
   parameter logic [7:0] SOP_PATTERN = 8'h3C,
   parameter logic [7:0] EOP_PATTERN = 8'hDC
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                enable,
   input  wire logic [1:0]          rx_elink2bit,
   elink_rx_deframer_2bit_if.master m_frame,
   output logic                     frame_err,
   output logic                     overflow,
   output logic [7:0]               err_cnt,
   output logic [15:0]              frame_cnt,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_CHK     = 2'd2,
      S_EOP     = 2'd3
   } state_t;

   state_t       r_state;
   // Only the three most recent symbols are kept: together with the live
   // symbol they form the full 8-bit hunt window.
   logic [5:0]   r_hr;
   logic [5:0]   r_cnt;
   logic [75:0]  r_payload;
   logic [7:0]   r_chk;
   logic [5:0]   r_eop;
   logic [75:0]  r_frame_data;
   logic         r_frame_valid;
   logic         r_frame_err;
   logic         r_overflow;
   logic [7:0]   r_err_cnt;
   logic [15:0]  r_frame_cnt;
   logic         r_busy;

   logic [7:0]   w_sop_window;
   logic [7:0]   w_eop_byte;
   logic [79:0]  w_payload_ext;
   logic [7:0]   w_chk_calc;
   logic         w_good;
   logic         w_room;

   assign w_sop_window = {r_hr, rx_elink2bit};
   assign w_eop_byte   = {r_eop, rx_elink2bit};

   always_comb begin
      w_payload_ext = {r_payload, 4'b0000};
      w_chk_calc    = 8'h00;
      for (int i = 0; i < 10; i++) begin
         w_chk_calc = w_chk_calc ^ w_payload_ext[i*8 +: 8];
      end
   end

   assign w_good = (w_chk_calc == r_chk) && (w_eop_byte == EOP_PATTERN);
   // Output slot is free if empty or being drained on this same edge.
   assign w_room = !r_frame_valid || m_frame.frame_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_hr          <= '0;
         r_cnt         <= '0;
         r_payload     <= '0;
         r_chk         <= '0;
         r_eop         <= '0;
         r_frame_data  <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overflow    <= 1'b0;
         r_err_cnt     <= '0;
         r_frame_cnt   <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
         if (r_frame_valid && m_frame.frame_ready) begin
            r_frame_valid <= 1'b0;
         end

         if (!enable) begin
            r_state <= S_IDLE;
            r_hr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_hr <= w_sop_window[5:0];
                  if (w_sop_window == SOP_PATTERN) begin
                     r_state <= S_PAYLOAD;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                  end
               end
               S_PAYLOAD: begin
                  r_payload <= {r_payload[73:0], rx_elink2bit};
                  if (r_cnt == 6'd37) begin
                     r_cnt   <= '0;
                     r_state <= S_CHK;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
               S_CHK: begin
                  r_chk <= {r_chk[5:0], rx_elink2bit};
                  if (r_cnt == 6'd3) begin
                     r_cnt   <= '0;
                     r_state <= S_EOP;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
               S_EOP: begin
                  r_eop <= w_eop_byte[5:0];
                  if (r_cnt == 6'd3) begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                     r_hr    <= '0;
                     r_busy  <= 1'b0;
                     if (w_good) begin
                        if (w_room) begin
                           // Overrides the drain above when both coincide.
                           r_frame_data  <= r_payload;
                           r_frame_valid <= 1'b1;
                           r_frame_cnt   <= r_frame_cnt + 16'd1;
                        end else begin
                           r_overflow <= 1'b1;
                        end
                     end else begin
                        r_frame_err <= 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                           r_err_cnt <= r_err_cnt + 8'd1;
                        end
                     end
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign m_frame.frame_data  = r_frame_data;
   assign m_frame.frame_valid = r_frame_valid;
   assign frame_err           = r_frame_err;
   assign overflow            = r_overflow;
   assign err_cnt             = r_err_cnt;
   assign frame_cnt           = r_frame_cnt;
   assign busy                = r_busy;

endmodule
`default_nettype wire
